// File: rtl/l1c_data_2way.sv
// 2-way set-associative write-through, no-write-allocate L1 data cache with
// per-set LRU, whole-line refill by single-word beats, flush and event counters.
module l1c_data_2way #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_in,
  input  logic [2:0]  core_type,
  output logic [31:0] core_out,
  output logic        core_wait,
  input  logic        flush,
  output logic        D_req,
  output logic [31:0] D_addr,
  output logic        D_write,
  output logic [31:0] D_in,
  output logic [2:0]  D_type,
  input  logic [31:0] D_out,
  input  logic        D_wait,
  output logic [31:0] rd_hit_cnt,
  output logic [31:0] rd_miss_cnt,
  output logic [31:0] wr_hit_cnt,
  output logic [31:0] wr_miss_cnt
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  localparam logic [2:0] CACHE_BYTE  = 3'b000;
  localparam logic [2:0] CACHE_HWORD = 3'b001;
  localparam logic [2:0] CACHE_WORD  = 3'b010;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE} state_e;

  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic victim_q, victim_d;
  logic wr_hit_q, wr_hit_d;
  logic wr_way_q, wr_way_d;
  logic flush_pend_q, flush_pend_d;

  logic [SETS-1:0] valid_q [2];
  logic [SETS-1:0] lru_q;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [31:0] data_q [2][SETS][LINE_WORDS];

  logic [31:0] rd_hit_q, rd_miss_q, wr_hit_q_cnt, wr_miss_q;
  logic        d_write_q;
  logic [31:0] d_addr_q, d_in_q;
  logic [2:0]  d_type_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [BEAT_W-1:0] wsel;
  logic hit0, hit1, hit, hit_way;
  logic inv_all, fill_last, lru_we, lru_val;
  logic inc_rd_hit, inc_rd_miss, inc_wr_hit, inc_wr_miss;
  logic [3:0] wr_mask;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] t, input logic [1:0] a);
    case (t)
      CACHE_BYTE:  return 4'b0001 << a;
      CACHE_HWORD: return a[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  assign idx     = core_addr[OFF_W+IDX_W-1:OFF_W];
  assign tag     = core_addr[31:OFF_W+IDX_W];
  assign wsel    = core_addr[OFF_W-1:2];
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign wr_mask = lane_mask(core_type, core_addr[1:0]);

  assign rd_hit_cnt  = rd_hit_q;
  assign rd_miss_cnt = rd_miss_q;
  assign wr_hit_cnt  = wr_hit_q_cnt;
  assign wr_miss_cnt = wr_miss_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    wr_hit_d     = wr_hit_q;
    wr_way_d     = wr_way_q;
    flush_pend_d = flush_pend_q || (flush && (state_q != S_IDLE));
    core_wait    = 1'b1;
    core_out     = 32'd0;
    D_req        = 1'b0;
    D_write      = d_write_q;
    D_addr       = d_addr_q;
    D_in         = d_in_q;
    D_type       = d_type_q;
    inv_all      = 1'b0;
    fill_last    = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    inc_rd_hit   = 1'b0;
    inc_rd_miss  = 1'b0;
    inc_wr_hit   = 1'b0;
    inc_wr_miss  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          inv_all      = 1'b1;
          flush_pend_d = 1'b0;
        end
        // A deferred flush consumes this IDLE cycle before any new lookup.
        if (core_req && !flush_pend_q) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (core_write) begin
          state_d     = S_WRITE;
          wr_hit_d    = hit;
          wr_way_d    = hit_way;
          inc_wr_hit  = hit;
          inc_wr_miss = !hit;
        end else if (hit) begin
          core_wait  = 1'b0;
          core_out   = data_q[hit_way][idx][wsel];
          lru_we     = 1'b1;
          lru_val    = !hit_way;
          inc_rd_hit = 1'b1;
          state_d    = S_IDLE;
        end else begin
          victim_d    = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
          beat_d      = '0;
          inc_rd_miss = 1'b1;
          state_d     = S_REFILL;
        end
      end
      S_REFILL: begin
        D_req   = 1'b1;
        D_write = 1'b0;
        D_type  = CACHE_WORD;
        D_addr  = {core_addr[31:OFF_W], beat_q, 2'b00};
        if (!D_wait) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            fill_last = 1'b1;
            core_wait = 1'b0;
            core_out  = (wsel == LAST_BEAT) ? D_out : data_q[victim_q][idx][wsel];
            lru_we    = 1'b1;
            lru_val   = !victim_q;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        D_req     = 1'b1;
        D_write   = 1'b1;
        D_addr    = core_addr;
        D_in      = core_in;
        D_type    = core_type;
        core_wait = D_wait;
        if (!D_wait) begin
          lru_we  = wr_hit_q;
          lru_val = !wr_way_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, valid/LRU, counters and held bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      victim_q     <= 1'b0;
      wr_hit_q     <= 1'b0;
      wr_way_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
      rd_hit_q     <= '0;
      rd_miss_q    <= '0;
      wr_hit_q_cnt <= '0;
      wr_miss_q    <= '0;
      d_write_q    <= 1'b0;
      d_addr_q     <= '0;
      d_in_q       <= '0;
      d_type_q     <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      victim_q     <= victim_d;
      wr_hit_q     <= wr_hit_d;
      wr_way_q     <= wr_way_d;
      flush_pend_q <= flush_pend_d;
      d_write_q    <= D_write;
      d_addr_q     <= D_addr;
      d_in_q       <= D_in;
      d_type_q     <= D_type;
      if (inv_all) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
        lru_q      <= '0;
      end else begin
        if (fill_last) valid_q[victim_q][idx] <= 1'b1;
        if (lru_we)    lru_q[idx] <= lru_val;
      end
      if (inc_rd_hit)  rd_hit_q     <= sat_inc(rd_hit_q);
      if (inc_rd_miss) rd_miss_q    <= sat_inc(rd_miss_q);
      if (inc_wr_hit)  wr_hit_q_cnt <= sat_inc(wr_hit_q_cnt);
      if (inc_wr_miss) wr_miss_q    <= sat_inc(wr_miss_q);
    end
  end

  // Tag and data storage: refill beats and byte-masked write-hit updates.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && !D_wait) begin
      data_q[victim_q][idx][beat_q] <= D_out;
      if (beat_q == LAST_BEAT) tag_q[victim_q][idx] <= tag;
    end
    if (state_q == S_WRITE && !D_wait && wr_hit_q) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) data_q[wr_way_q][idx][wsel][8*b +: 8] <= core_in[8*b +: 8];
    end
  end

  a_one_hit_way : assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOOKUP) |-> !(hit0 && hit1));

endmodule

// File: tb/tb_l1c_data_2way.sv
// Directed bench for l1c_data_2way: scoreboarded bus beats and load data
// against a word-addressed memory model that defaults to word(addr)=addr.
module tb_l1c_data_2way;
  localparam logic [2:0] C_BYTE  = 3'b000;
  localparam logic [2:0] C_HWORD = 3'b001;
  localparam logic [2:0] C_WORD  = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_write = 1'b0;
  logic [31:0] core_addr = '0, core_in = '0;
  logic [2:0]  core_type = '0;
  logic [31:0] core_out;
  logic        core_wait;
  logic        flush = 1'b0;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out = '0;
  logic        D_wait = 1'b0;
  logic [31:0] rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt;

  l1c_data_2way dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_write(core_write),
    .core_addr(core_addr), .core_in(core_in), .core_type(core_type),
    .core_out(core_out), .core_wait(core_wait), .flush(flush),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
    .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
    .rd_hit_cnt(rd_hit_cnt), .rd_miss_cnt(rd_miss_cnt),
    .wr_hit_cnt(wr_hit_cnt), .wr_miss_cnt(wr_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
  } beat_t;

  int checks = 0;
  int errors = 0;
  beat_t exp_bus[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int stall_left = 0;
  int stall_seen = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder and bus scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    logic [31:0] a, w;
    logic [3:0] m;
    D_wait = 1'b0;
    if (D_req && D_addr == stall_addr) begin
      stall_seen++;
      if (stall_left > 0) begin
        D_wait = 1'b1;
        stall_left--;
      end
    end
    a = {D_addr[31:2], 2'b00};
    D_out = mem_rd(a);
    if (D_req && !D_wait && !rst) begin
      checks++;
      assert (exp_bus.size() != 0) else begin
        errors++;
        $error("FAIL bus_unexpected: observed beat at %h expected none", D_addr);
      end
      if (exp_bus.size() != 0) begin
        e = exp_bus.pop_front();
        checks++;
        assert (D_addr === e.addr && D_write === e.wr && D_type === e.typ &&
                (!e.wr || D_in === e.data)) else begin
          errors++;
          $error("FAIL bus_beat: observed wr=%b addr=%h data=%h type=%0d expected wr=%b addr=%h data=%h type=%0d",
                 D_write, D_addr, D_in, D_type, e.wr, e.addr, e.data, e.typ);
        end
        if (D_write) begin
          case (D_type)
            C_BYTE:  m = 4'b0001 << D_addr[1:0];
            C_HWORD: m = D_addr[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
          endcase
          w = mem_rd(a);
          for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = D_in[8*b +: 8];
          mem[a] = w;
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_bus.push_back('{1'b0, base + 32'(4*i), 32'd0, C_WORD});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    exp_bus.push_back('{1'b1, a, d, t});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_core_wait"}, 32'(core_wait), 32'd1);
    chk({tag, "_core_out"}, core_out, 32'd0);
    chk({tag, "_D_req"}, 32'(D_req), 32'd0);
    chk({tag, "_D_write"}, 32'(D_write), 32'd0);
    chk({tag, "_D_addr"}, D_addr, 32'd0);
    chk({tag, "_D_in"}, D_in, 32'd0);
    chk({tag, "_D_type"}, 32'(D_type), 32'd0);
    chk({tag, "_rd_hit"}, rd_hit_cnt, 32'd0);
    chk({tag, "_rd_miss"}, rd_miss_cnt, 32'd0);
    chk({tag, "_wr_hit"}, wr_hit_cnt, 32'd0);
    chk({tag, "_wr_miss"}, wr_miss_cnt, 32'd0);
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic access(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] din, input logic [2:0] t,
                        input logic [31:0] exp_data, input int exp_lat,
                        input bit flush_last, input int rst_cyc);
    int cyc;
    bit done, aborted;
    logic [31:0] e;
    cyc = 0; done = 0; aborted = 0;
    if (!wr) exp_rd.push_back(exp_data);
    core_req = 1'b1; core_write = wr; core_addr = a; core_in = din; core_type = t;
    while (!done && !aborted && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        check_reset({tag, "_midrst"});
        aborted = 1;
      end else if (core_wait === 1'b0) begin
        done = 1;
        if (!wr) begin
          e = exp_rd.pop_front();
          chk({tag, "_data"}, core_out, e);
        end
        if (flush_last) flush = 1'b1;
      end
    end
    if (aborted) begin
      if (!wr) void'(exp_rd.pop_front());
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    flush = 1'b0;
    chk({tag, "_bus_left"}, 32'(exp_bus.size()), 32'd0);
    exp_bus.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    push_refill(32'h100);
    access("cold_rd", 0, 32'h104, 0, C_WORD, 32'h104, 6, 0, 0);
    chk("cold_rd_miss_cnt", rd_miss_cnt, 32'd1);
    access("rd_hit", 0, 32'h104, 0, C_WORD, 32'h104, 2, 0, 0);
    chk("rd_hit_cnt1", rd_hit_cnt, 32'd1);

    access("hit_100", 0, 32'h100, 0, C_WORD, 32'h100, 2, 0, 0);
    push_refill(32'h500);
    access("miss_500", 0, 32'h500, 0, C_WORD, 32'h500, 6, 0, 0);
    push_refill(32'h900);
    access("miss_900", 0, 32'h900, 0, C_WORD, 32'h900, 6, 0, 0);
    access("hit_500", 0, 32'h500, 0, C_WORD, 32'h500, 2, 0, 0);
    push_refill(32'h100);
    access("evicted_100", 0, 32'h100, 0, C_WORD, 32'h100, 6, 0, 0);
    chk("lru_rd_hit_cnt", rd_hit_cnt, 32'd3);
    chk("lru_rd_miss_cnt", rd_miss_cnt, 32'd4);

    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    mem[32'h100] = 32'h1122_3344;
    push_refill(32'h100);
    access("post_flush", 0, 32'h100, 0, C_WORD, 32'h1122_3344, 6, 0, 0);

    push_write(32'h102, 32'h00AB_0000, C_BYTE);
    access("st_byte", 1, 32'h102, 32'h00AB_0000, C_BYTE, 0, 3, 0, 0);
    chk("st_byte_wr_hit", wr_hit_cnt, 32'd1);
    access("ld_byte", 0, 32'h100, 0, C_WORD, 32'h11AB_3344, 2, 0, 0);
    push_write(32'h106, 32'hBEEF_0000, C_HWORD);
    access("st_half", 1, 32'h106, 32'hBEEF_0000, C_HWORD, 0, 3, 0, 0);
    access("ld_half", 0, 32'h104, 0, C_WORD, 32'hBEEF_0104, 2, 0, 0);
    chk("st_wr_hit_cnt", wr_hit_cnt, 32'd2);

    push_write(32'hF00, 32'hDEAD_BEEF, C_WORD);
    access("st_miss", 1, 32'hF00, 32'hDEAD_BEEF, C_WORD, 0, 3, 0, 0);
    chk("st_miss_wr_miss", wr_miss_cnt, 32'd1);
    push_refill(32'hF00);
    access("ld_after_stmiss", 0, 32'hF00, 0, C_WORD, 32'hDEAD_BEEF, 6, 0, 0);
    chk("rd_miss_cnt6", rd_miss_cnt, 32'd6);

    stall_addr = 32'h208; stall_left = 5; stall_seen = 0;
    push_refill(32'h200);
    access("stall_rd", 0, 32'h208, 0, C_WORD, 32'h208, 11, 1, 0);
    chk("stall_addr_cycles", 32'(stall_seen), 32'd6);
    stall_addr = 32'hFFFF_FFFF;
    push_refill(32'h200);
    access("flushed_rd", 0, 32'h208, 0, C_WORD, 32'h208, 7, 0, 0);
    push_refill(32'h100);
    access("flushed_100", 0, 32'h100, 0, C_WORD, 32'h11AB_3344, 6, 0, 0);
    chk("rd_miss_cnt9", rd_miss_cnt, 32'd9);

    push_refill(32'h300);
    access("rst_refill", 0, 32'h300, 0, C_WORD, 32'h300, 0, 0, 6);
    push_refill(32'h300);
    access("rerq_300", 0, 32'h300, 0, C_WORD, 32'h300, 6, 0, 0);
    push_refill(32'h100);
    access("rerq_100", 0, 32'h100, 0, C_WORD, 32'h11AB_3344, 6, 0, 0);
    chk("post_rst_rd_miss", rd_miss_cnt, 32'd2);
    chk("post_rst_rd_hit", rd_hit_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
